// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for icache fill, dcache miss and dcache write queue; one access in flight,
// completion (wait low) one or more cycles after grant. Optional icache anti-starvation: MEMARB_ANTISTARVE_EN.
module memory_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dmissREN,
  input  logic [ADDR_W-1:0] dmissaddr,
  output logic              dmisswait,
  output logic [DATA_W-1:0] dload,
  input  logic              dqueueWEN,
  input  logic [ADDR_W-1:0] wdaddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  typedef enum logic [1:0] {IDLE, IREAD, DREAD, WRITE} state_t;

  state_t state, state_n;
  logic   i_done, d_done, w_done;
  logic   starve_prio;

  // Completion is suppressed while reset is asserted so an aborted access never pulses a wait.
  assign i_done = (state == IREAD) && ram_ready && !n_rst;
  assign d_done = (state == DREAD) && ram_ready && !n_rst;
  assign w_done = (state == WRITE) && ram_ready && !n_rst;

  assign iwait     = !i_done;
  assign dmisswait = !d_done;
  assign dwait     = !w_done;
  assign iload     = i_done ? ramload : '0;
  assign dload     = d_done ? ramload : '0;

`ifdef MEMARB_ANTISTARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      starve_cnt <= '0;
    end else if (!iREN || i_done) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign starve_prio = (starve_cnt == CNT_W'(STARVE_LIMIT));
`else
  // No promotion in this build; the comparison is constant false but keeps STARVE_LIMIT referenced.
  assign starve_prio = (STARVE_LIMIT < 0);
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (dmissREN)                  state_n = DREAD;
        else if (starve_prio && iREN)  state_n = IREAD;
        else if (dqueueWEN)            state_n = WRITE;
        else if (iREN)                 state_n = IREAD;
      end
      default: begin
        if (ram_ready) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state    <= IDLE;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        ramREN <= (state_n == IREAD) || (state_n == DREAD);
        ramWEN <= (state_n == WRITE);
        case (state_n)
          IREAD: ramaddr <= iaddr;
          DREAD: ramaddr <= dmissaddr;
          WRITE: begin
            ramaddr  <= wdaddr;
            ramstore <= dstore;
          end
          default: ;
        endcase
      end else if (ram_ready) begin
        ramREN <= 1'b0;
        ramWEN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a completion scoreboard; build with or without MEMARB_ANTISTARVE_EN.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        iREN, dmissREN, dqueueWEN, ram_ready;
  logic [31:0] iaddr, dmissaddr, wdaddr, dstore, ramload;
  logic        iwait, dmisswait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          kind;   // 0 icache read, 1 dcache read, 2 write
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dmissREN(dmissREN), .dmissaddr(dmissaddr), .dmisswait(dmisswait), .dload(dload),
    .dqueueWEN(dqueueWEN), .wdaddr(wdaddr), .dstore(dstore), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic exp_t mk(input int k, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

  // Monitor: every completion pops the oldest expected transaction.
  always @(negedge clk) begin
    if (mon_en) begin
      int   nlow;
      int   which;
      exp_t e;
      nlow = int'(!iwait) + int'(!dmisswait) + int'(!dwait);
      which = !iwait ? 0 : (!dmisswait ? 1 : 2);
      check("ren_wen_excl", {31'd0, ramREN & ramWEN}, 32'd0);
      if (iwait)     check("iload_zero", iload, 32'd0);
      if (dmisswait) check("dload_zero", dload, 32'd0);
      if (nlow > 1) check("single_wait_low", nlow, 1);
      if (nlow == 1) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_completion", which, 99);
        end else begin
          e = exp_q.pop_front();
          check("sb_kind", which, e.kind);
          check("sb_addr", ramaddr, e.addr);
          case (e.kind)
            0: begin check("sb_iload", iload, e.data); check("sb_iread_en", {31'd0, ramREN}, 32'd1); end
            1: begin check("sb_dload", dload, e.data); check("sb_dread_en", {31'd0, ramREN}, 32'd1); end
            default: begin check("sb_wdata", ramstore, e.data); check("sb_write_en", {31'd0, ramWEN}, 32'd1); end
          endcase
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic iw, dw, ww;
    // Test 1: reset with all requests high
    n_rst = 1'b1; iREN = 1'b1; dmissREN = 1'b1; dqueueWEN = 1'b1; ram_ready = 1'b1;
    iaddr = 32'h11; dmissaddr = 32'h22; wdaddr = 32'h33; dstore = 32'h44; ramload = 32'h55;
    cyc();
    mon_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      smp();
      check("rst_ramREN", {31'd0, ramREN}, 32'd0);
      check("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
      check("rst_ramaddr", ramaddr, 32'd0);
      check("rst_ramstore", ramstore, 32'd0);
      check("rst_waits", {29'd0, iwait, dmisswait, dwait}, 32'd7);
      cyc();
    end
    n_rst = 1'b0; iREN = 1'b0; dmissREN = 1'b0; dqueueWEN = 1'b0; ram_ready = 1'b0;
    smp();
    check("post_rst_idle_en", {30'd0, ramREN, ramWEN}, 32'd0);
    check("post_rst_waits", {29'd0, iwait, dmisswait, dwait}, 32'd7);

    // Test 2: icache read, RAM ready in cycle 3
    cyc();
    iREN = 1'b1; iaddr = 32'h100; ramload = 32'hDEADBEEF;
    exp_q.push_back(mk(0, 32'h100, 32'hDEADBEEF));
    smp();
    check("t2_c0_ramREN", {31'd0, ramREN}, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      ram_ready = (c == 3);
      smp();
      check("t2_ramREN", {31'd0, ramREN}, 32'd1);
      check("t2_ramaddr", ramaddr, 32'h100);
      check("t2_iwait", {31'd0, iwait}, {31'd0, c != 3});
    end
    cyc();
    iREN = 1'b0; ram_ready = 1'b0;
    smp();
    check("t2_c4_ramREN", {31'd0, ramREN}, 32'd0);
    check("t2_c4_iwait", {31'd0, iwait}, 32'd1);

    // Test 3: single write, ram_ready always high (also ignored in IDLE)
    cyc();
    dqueueWEN = 1'b1; wdaddr = 32'h40; dstore = 32'h12345678; ram_ready = 1'b1;
    exp_q.push_back(mk(2, 32'h40, 32'h12345678));
    smp();
    check("t3_c0_dwait", {31'd0, dwait}, 32'd1);
    cyc();
    smp();
    check("t3_c1_ramWEN", {31'd0, ramWEN}, 32'd1);
    check("t3_c1_dwait", {31'd0, dwait}, 32'd0);
    cyc();
    dqueueWEN = 1'b0;
    smp();
    check("t3_c2_ramWEN", {31'd0, ramWEN}, 32'd0);
    check("t3_c2_dwait", {31'd0, dwait}, 32'd1);

    // Test 4: three simultaneous requests, completions at cycles 1, 3, 5
    cyc();
    dmissREN = 1'b1; dmissaddr = 32'h200; dqueueWEN = 1'b1; wdaddr = 32'h300; dstore = 32'hABCD0300;
    iREN = 1'b1; iaddr = 32'h400; ramload = 32'hA5A50001; ram_ready = 1'b1;
    exp_q.push_back(mk(1, 32'h200, 32'hA5A50001));
    exp_q.push_back(mk(2, 32'h300, 32'hABCD0300));
    exp_q.push_back(mk(0, 32'h400, 32'hA5A50001));
    for (int c = 0; c < 7; c++) begin
      smp();
      check("t4_dmisswait", {31'd0, dmisswait}, {31'd0, c != 1});
      check("t4_dwait", {31'd0, dwait}, {31'd0, c != 3});
      check("t4_iwait", {31'd0, iwait}, {31'd0, c != 5});
      iw = !iwait; dw = !dmisswait; ww = !dwait;
      cyc();
      if (iw) iREN = 1'b0;
      if (dw) dmissREN = 1'b0;
      if (ww) dqueueWEN = 1'b0;
    end
    ram_ready = 1'b0;

    // Test 5: reset mid-read aborts with no completion pulse
    dmissREN = 1'b1; dmissaddr = 32'h80;
    smp();
    cyc();
    smp();
    check("t5_c1_ramREN", {31'd0, ramREN}, 32'd1);
    cyc();
    n_rst = 1'b1; ram_ready = 1'b1;
    smp();
    check("t5_c2_dmisswait", {31'd0, dmisswait}, 32'd1);
    cyc();
    n_rst = 1'b0; ram_ready = 1'b0; dmissREN = 1'b0;
    smp();
    check("t5_c3_ramREN", {31'd0, ramREN}, 32'd0);
    check("t5_c3_ramaddr", ramaddr, 32'd0);
    check("t5_c3_dmisswait", {31'd0, dmisswait}, 32'd1);

    // Test 6: write queue held against icache, starvation behaviour
    cyc();
    dqueueWEN = 1'b1; wdaddr = 32'h600; dstore = 32'h0000F00D;
    iREN = 1'b1; iaddr = 32'h700; ramload = 32'h5A5A5A5A; ram_ready = 1'b1;
    exp_q.push_back(mk(2, 32'h600, 32'h0000F00D));
    exp_q.push_back(mk(2, 32'h600, 32'h0000F00D));
`ifdef MEMARB_ANTISTARVE_EN
    exp_q.push_back(mk(0, 32'h700, 32'h5A5A5A5A));
`else
    exp_q.push_back(mk(2, 32'h600, 32'h0000F00D));
`endif
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(2, 32'h600, 32'h0000F00D));
    for (int c = 0; c < 12; c++) begin
      smp();
`ifdef MEMARB_ANTISTARVE_EN
      check("t6_iwait", {31'd0, iwait}, {31'd0, c != 5});
      check("t6_dwait", {31'd0, dwait}, {31'd0, !(c == 1 || c == 3 || c == 7 || c == 9 || c == 11)});
`else
      check("t6_iwait", {31'd0, iwait}, 32'd1);
      check("t6_dwait", {31'd0, dwait}, {31'd0, (c % 2) == 0});
`endif
      iw = !iwait;
      cyc();
      if (iw) iREN = 1'b0;
    end
    dqueueWEN = 1'b0; iREN = 1'b0; ram_ready = 1'b0;

    // Test 7: dcache miss arrives in the write completion cycle; entry is rewritten later
    dqueueWEN = 1'b1; wdaddr = 32'h500; dstore = 32'hCAFEF00D; ramload = 32'h600D600D;
    exp_q.push_back(mk(2, 32'h500, 32'hCAFEF00D));
    exp_q.push_back(mk(1, 32'h600, 32'h600D600D));
    exp_q.push_back(mk(2, 32'h500, 32'hCAFEF00D));
    smp();
    cyc();
    smp();
    check("t7_c1_ramWEN", {31'd0, ramWEN}, 32'd1);
    cyc();
    ram_ready = 1'b1; dmissREN = 1'b1; dmissaddr = 32'h600;
    smp();
    check("t7_c2_dwait", {31'd0, dwait}, 32'd0);
    check("t7_c2_dmisswait", {31'd0, dmisswait}, 32'd1);
    cyc();
    smp();
    check("t7_c3_idle", {30'd0, ramREN, ramWEN}, 32'd0);
    cyc();
    smp();
    check("t7_c4_dmisswait", {31'd0, dmisswait}, 32'd0);
    cyc();
    dmissREN = 1'b0;
    smp();
    check("t7_c5_idle", {30'd0, ramREN, ramWEN}, 32'd0);
    cyc();
    smp();
    check("t7_c6_dwait", {31'd0, dwait}, 32'd0);
    cyc();
    dqueueWEN = 1'b0; ram_ready = 1'b0;
    smp();
    check("t7_c7_idle", {30'd0, ramREN, ramWEN}, 32'd0);

    cyc();
    check("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
